// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw pins in, debounced level and per-channel event pulses out.
interface button_conditioner_if #(
   parameter int CHANNELS = 4
) ();
   logic [CHANNELS-1:0] btn_in;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] press;
   logic [CHANNELS-1:0] release_pulse;
   logic [CHANNELS-1:0] long_press;
   logic [CHANNELS-1:0] repeat_pulse;
   logic                any_pressed;

   modport master (
      output btn_in,
      input  level, press, release_pulse, long_press, repeat_pulse, any_pressed
   );

   modport slave (
      input  btn_in,
      output level, press, release_pulse, long_press, repeat_pulse, any_pressed
   );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel button synchroniser, debouncer and press/release/long-press/repeat pulse generator.
// Define BTN_REPEAT_EN to enable auto-repeat pulses after long_press; otherwise repeat_pulse is 0.
module button_conditioner #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input logic                 clock,
   input logic                 reset_n,
   button_conditioner_if.slave bus
);
   localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam logic [CHANNELS-1:0] PIN_IDLE = ACTIVE_LOW ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

   if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("button_conditioner: illegal parameter combination");
   end

`ifdef BTN_REPEAT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} hold_state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} hold_state_t;
`endif

   logic [CHANNELS-1:0] sync_p0, sync_p1, raw_p;
   logic [CHANNELS-1:0] level_q, press_q, release_q, long_q;
   logic [CHANNELS-1:0] flip, long_nxt;
   logic [DEB_W-1:0]    deb_cnt [CHANNELS];
   logic [HOLD_W-1:0]   hold_cnt [CHANNELS];
   logic [HOLD_W-1:0]   hold_cnt_nxt [CHANNELS];
   hold_state_t         state [CHANNELS];
   hold_state_t         state_nxt [CHANNELS];

   // flip: the debounced level toggles on the coming edge
   always_comb begin
      flip = '0;
      for (int i = 0; i < CHANNELS; i++)
         flip[i] = (raw_p[i] != level_q[i]) && (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0   <= PIN_IDLE;
         sync_p1   <= PIN_IDLE;
         raw_p     <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < CHANNELS; i++) deb_cnt[i] <= '0;
      end else begin
         sync_p0   <= bus.btn_in;
         sync_p1   <= sync_p0;
         raw_p     <= ACTIVE_LOW ? ~sync_p1 : sync_p1;
         level_q   <= level_q ^ flip;
         press_q   <= flip & ~level_q;
         release_q <= flip & level_q;
         for (int i = 0; i < CHANNELS; i++) begin
            if (raw_p[i] == level_q[i] || flip[i]) deb_cnt[i] <= '0;
            else                                   deb_cnt[i] <= deb_cnt[i] + 1'b1;
         end
      end
   end

   // Hold FSM: state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state[i]    <= ST_IDLE;
            hold_cnt[i] <= '0;
         end
         long_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state[i]    <= state_nxt[i];
            hold_cnt[i] <= hold_cnt_nxt[i];
         end
         long_q <= long_nxt;
      end
   end

   // Hold FSM: next state; a level fall overrides everything
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_nxt[i]    = state[i];
         hold_cnt_nxt[i] = hold_cnt[i];
         if (flip[i] && level_q[i]) begin
            state_nxt[i]    = ST_IDLE;
            hold_cnt_nxt[i] = '0;
         end else begin
            case (state[i])
               ST_IDLE: begin
                  if (flip[i]) begin
                     state_nxt[i]    = ST_HELD;
                     hold_cnt_nxt[i] = '0;
                  end
               end
               ST_HELD: begin
                  if (hold_cnt[i] == HOLD_W'(LONG_CYCLES - 1)) begin
`ifdef BTN_REPEAT_EN
                     state_nxt[i]    = ST_REPEAT;
`else
                     state_nxt[i]    = ST_LONG;
`endif
                     hold_cnt_nxt[i] = '0;
                  end else begin
                     hold_cnt_nxt[i] = hold_cnt[i] + 1'b1;
                  end
               end
`ifdef BTN_REPEAT_EN
               ST_REPEAT: begin
                  if (hold_cnt[i] == HOLD_W'(REPEAT_CYCLES - 1)) hold_cnt_nxt[i] = '0;
                  else                                           hold_cnt_nxt[i] = hold_cnt[i] + 1'b1;
               end
`else
               ST_LONG: ;
`endif
               default: begin
                  state_nxt[i]    = ST_IDLE;
                  hold_cnt_nxt[i] = '0;
               end
            endcase
         end
      end
   end

   // Hold FSM: pulse outputs, registered by the state register process
   always_comb begin
      long_nxt = '0;
      for (int i = 0; i < CHANNELS; i++)
         long_nxt[i] = (state[i] == ST_HELD) && (hold_cnt[i] == HOLD_W'(LONG_CYCLES - 1))
                       && !(flip[i] && level_q[i]);
   end

`ifdef BTN_REPEAT_EN
   logic [CHANNELS-1:0] repeat_nxt, repeat_q;

   always_comb begin
      repeat_nxt = '0;
      for (int i = 0; i < CHANNELS; i++)
         repeat_nxt[i] = (state[i] == ST_REPEAT) && (hold_cnt[i] == HOLD_W'(REPEAT_CYCLES - 1))
                         && !(flip[i] && level_q[i]);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) repeat_q <= '0;
      else          repeat_q <= repeat_nxt;
   end

   assign bus.repeat_pulse = repeat_q;
`else
   assign bus.repeat_pulse = '0;
`endif

   assign bus.level         = level_q;
   assign bus.press         = press_q;
   assign bus.release_pulse = release_q;
   assign bus.long_press    = long_q;
   assign bus.any_pressed   = |level_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a window-based behavioural model.
module tb_button_conditioner;
   localparam int CH = 2;
   localparam int D  = 4;
   localparam int L  = 20;
   localparam int R  = 5;
`ifdef BTN_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   button_conditioner_if #(.CHANNELS(CH)) bus ();

   button_conditioner #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Model: pressed samples history, level flips when the D samples taken
   // 3..D+2 edges ago all disagree with the current level.
   bit       hist [CH][D+2];
   bit       m_level [CH];
   int       m_t0 [CH];
   bit [CH-1:0] e_level, e_press, e_rel, e_long, e_rep;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < CH; c++) begin
            m_level[c] = 1'b0;
            m_t0[c]    = 0;
            for (int j = 0; j < D + 2; j++) hist[c][j] = 1'b0;
         end
         e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      end else begin
         cyc++;
         for (int c = 0; c < CH; c++) begin
            bit all_diff;
            bit nl;
            int age;
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++)
               if (hist[c][j] == m_level[c]) all_diff = 1'b0;
            nl = all_diff ? ~m_level[c] : m_level[c];
            e_press[c] = nl & ~m_level[c];
            e_rel[c]   = ~nl & m_level[c];
            if (e_press[c]) m_t0[c] = cyc;
            age = cyc - m_t0[c];
            e_long[c] = nl && m_level[c] && (age == L);
            e_rep[c]  = REP_EN && nl && m_level[c] && (age > L) && ((age - L) % R == 0);
            m_level[c] = nl;
            e_level[c] = nl;
            for (int j = D + 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = ~bus.btn_in[c];
         end
      end
   end

   always @(negedge clock) begin
      check("level",       32'(bus.level),         32'(e_level));
      check("press",       32'(bus.press),         32'(e_press));
      check("release",     32'(bus.release_pulse), 32'(e_rel));
      check("long_press",  32'(bus.long_press),    32'(e_long));
      check("repeat",      32'(bus.repeat_pulse),  32'(e_rep));
      check("any_pressed", 32'(bus.any_pressed),   32'(|e_level));
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic hold(input int c, input int n, input int after);
      @(negedge clock);
      bus.btn_in[c] = 1'b0;
      idle(n);
      bus.btn_in[c] = 1'b1;
      idle(after);
   endtask

   initial begin
      bus.btn_in = '1;
      idle(4);
      #2 reset_n = 1'b1;
      idle(4);

      // clean press / release on channel 0
      hold(0, 12, 14);

      // bounce every 2 cycles, then settle low
      @(negedge clock);
      for (int k = 0; k < 15; k++) begin
         bus.btn_in[0] = k[0];
         idle(2);
      end
      bus.btn_in[0] = 1'b0;
      idle(12);
      bus.btn_in[0] = 1'b1;
      idle(14);

      // long press with repeats on channel 1
      hold(1, 60, 16);

      // release timing sweep around the long_press edge
      for (int n = 16; n <= 28; n++) hold(n % 2, n, 12);

      // reset in the middle of a hold on both channels
      @(negedge clock);
      bus.btn_in = '0;
      idle(40);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 check("async_reset", {26'd0, bus.any_pressed, bus.level, bus.press, bus.long_press},
                              32'd0);
      idle(3);
      #2 reset_n = 1'b1;
      idle(40);
      bus.btn_in = '1;
      idle(14);

      // random segments with mixed short bounces and long holds
      for (int s = 0; s < 200; s++) begin
         int c;
         int len;
         c = $urandom_range(0, CH - 1);
         case ($urandom_range(0, 2))
            0:       len = $urandom_range(1, D);
            1:       len = $urandom_range(D, 3 * D);
            default: len = $urandom_range(L - 3, L + 4 * R);
         endcase
         @(negedge clock);
         bus.btn_in[c] = ~bus.btn_in[c];
         idle(len);
      end
      bus.btn_in = '1;
      idle(20);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
